// File: rtl/local_port_serializer_if.sv
// Packet-in / nibble-out bundle for the router local-port serializer.
// master = upstream writer plus downstream sink; slave = the serializer.
interface local_port_serializer_if #(
    parameter int PACKET_WIDTH = 32,
    parameter int NIBBLE_WIDTH = 4
);
    logic                    write_req;
    logic [PACKET_WIDTH-1:0] spike_packet;
    logic                    in_full;
    logic                    overflow;
    logic [NIBBLE_WIDTH-1:0] nibble_out;
    logic                    write_enable;
    logic                    receive_full;
    logic                    packet_done;
    logic [15:0]             pkt_count;

    modport master (
        output write_req, spike_packet, receive_full,
        input  in_full, overflow, nibble_out, write_enable, packet_done, pkt_count
    );

    modport slave (
        input  write_req, spike_packet, receive_full,
        output in_full, overflow, nibble_out, write_enable, packet_done, pkt_count
    );
endinterface

// File: rtl/local_port_serializer.sv
// Buffers whole packets in a small FIFO and streams them as back-to-back
// nibble flits to the router local port, honouring the sink's full flag.
module local_port_serializer #(
    parameter int PACKET_WIDTH    = 32,
    parameter int NIBBLE_WIDTH    = 4,
    parameter int FIFO_ADDR_WIDTH = 2,
    parameter bit MSB_FIRST       = 1'b1
) (
    input logic                    rt_clk,
    input logic                    rt_reset,
    local_port_serializer_if.slave port
);

    localparam int DEPTH       = 1 << FIFO_ADDR_WIDTH;
    localparam int NUM_NIBBLES = PACKET_WIDTH / NIBBLE_WIDTH;
    localparam int IDX_W       = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam int CNT_W       = FIFO_ADDR_WIDTH + 1;

    localparam logic [IDX_W-1:0]           LAST_IDX  = IDX_W'(NUM_NIBBLES - 1);
    localparam logic [IDX_W-1:0]           IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0]           CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]           CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE   = FIFO_ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                     state;
    logic [PACKET_WIDTH-1:0]    mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [PACKET_WIDTH-1:0]    shreg;
    logic [IDX_W-1:0]           nib_idx;
    logic                       overflow;
    logic [15:0]                pkt_count;

    logic                       in_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       write_enable;
    logic                       packet_done;
    logic [NIBBLE_WIDTH-1:0]    nibble_out;
    logic [PACKET_WIDTH-1:0]    shreg_next;

    // Fullness comes only from the registered count, so a pop in the same
    // cycle never frees a slot for the write arriving alongside it.
    always_comb begin
        in_full      = (count == CNT_DEPTH);
        fifo_empty   = (count == '0);
        push         = port.write_req & ~in_full;
        write_enable = (state == SHIFT) & ~port.receive_full;
        packet_done  = write_enable & (nib_idx == LAST_IDX);
        pop          = ~fifo_empty & ((state == IDLE) | packet_done);
        nibble_out   = '0;
        if (state == SHIFT) begin
            nibble_out = MSB_FIRST ? shreg[PACKET_WIDTH-1 -: NIBBLE_WIDTH]
                                   : shreg[NIBBLE_WIDTH-1:0];
        end
        shreg_next   = MSB_FIRST ? (shreg << NIBBLE_WIDTH) : (shreg >> NIBBLE_WIDTH);
    end

    // NOTE: the packet array carries no reset; emptiness is tracked by the
    // pointers and count alone, so stale entries are never observed.
    always_ff @(posedge rt_clk) begin
        if (push) begin
            mem[wr_ptr] <= port.spike_packet;
        end
    end

    always_ff @(posedge rt_clk or posedge rt_reset) begin
        if (rt_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (port.write_req && in_full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge rt_clk or posedge rt_reset) begin
        if (rt_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            nib_idx   <= '0;
            pkt_count <= '0;
        end else begin
            if (packet_done) pkt_count <= pkt_count + 16'd1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        nib_idx <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (packet_done) begin
                        nib_idx <= '0;
                        if (pop) begin
                            shreg <= mem[rd_ptr];
                        end else begin
                            shreg <= shreg_next;
                            state <= IDLE;
                        end
                    end else if (write_enable) begin
                        shreg   <= shreg_next;
                        nib_idx <= nib_idx + IDX_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign port.in_full      = in_full;
    assign port.overflow     = overflow;
    assign port.nibble_out   = nibble_out;
    assign port.write_enable = write_enable;
    assign port.packet_done  = packet_done;
    assign port.pkt_count    = pkt_count;

endmodule

// File: tb/tb_local_port_serializer.sv
// Directed bench for local_port_serializer: one MSB-first and one LSB-first
// instance, driven 1 ns after the rising edge and sampled on the falling edge.
module tb_local_port_serializer;

    logic rt_clk = 1'b0;
    logic rt_reset;

    always #5 rt_clk = ~rt_clk;

    local_port_serializer_if #(.PACKET_WIDTH(32), .NIBBLE_WIDTH(4)) bus_a ();
    local_port_serializer_if #(.PACKET_WIDTH(32), .NIBBLE_WIDTH(4)) bus_b ();

    local_port_serializer #(
        .PACKET_WIDTH(32), .NIBBLE_WIDTH(4), .FIFO_ADDR_WIDTH(2), .MSB_FIRST(1'b1)
    ) dut_a (
        .rt_clk   (rt_clk),
        .rt_reset (rt_reset),
        .port     (bus_a)
    );

    local_port_serializer #(
        .PACKET_WIDTH(32), .NIBBLE_WIDTH(4), .FIFO_ADDR_WIDTH(2), .MSB_FIRST(1'b0)
    ) dut_b (
        .rt_clk   (rt_clk),
        .rt_reset (rt_reset),
        .port     (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int pd_pulses;
    int span;

    logic        s_we;
    logic [3:0]  s_nib;
    logic        s_pd;
    logic [15:0] s_cnt;
    logic        s_full;
    logic        s_ovf;

    logic [31:0] fill_pkts [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap(input bit sel);
        if (sel) begin
            s_we = bus_b.write_enable; s_nib = bus_b.nibble_out; s_pd = bus_b.packet_done;
            s_cnt = bus_b.pkt_count; s_full = bus_b.in_full; s_ovf = bus_b.overflow;
        end else begin
            s_we = bus_a.write_enable; s_nib = bus_a.nibble_out; s_pd = bus_a.packet_done;
            s_cnt = bus_a.pkt_count; s_full = bus_a.in_full; s_ovf = bus_a.overflow;
        end
    endtask

    // One clock cycle: drive just after the rising edge, sample at the falling edge.
    task automatic cycle(input bit sel, input bit wr, input logic [31:0] pkt, input bit rf);
        @(posedge rt_clk);
        #1;
        bus_a.write_req    = wr & ~sel;
        bus_a.spike_packet = pkt;
        bus_a.receive_full = rf & ~sel;
        bus_b.write_req    = wr & sel;
        bus_b.spike_packet = pkt;
        bus_b.receive_full = rf & sel;
        @(negedge rt_clk);
        snap(sel);
    endtask

    function automatic logic [3:0] exp_nib(input logic [31:0] pkt, input int i, input bit msb);
        logic [31:0] p;
        p = msb ? (pkt >> (28 - 4 * i)) : (pkt >> (4 * i));
        return p[3:0];
    endfunction

    // Eight unstalled cycles that must carry every nibble of pkt in order.
    task automatic expect_stream(input string tag, input bit sel, input logic [31:0] pkt,
                                 input bit msb);
        for (int i = 0; i < 8; i++) begin
            cycle(sel, 1'b0, 32'h0, 1'b0);
            check({tag, "_we"}, 32'(s_we), 32'd1);
            check({tag, "_nib"}, 32'(s_nib), 32'(exp_nib(pkt, i, msb)));
            check({tag, "_done"}, 32'(s_pd), (i == 7) ? 32'd1 : 32'd0);
            if (s_pd) pd_pulses++;
        end
    endtask

    task automatic do_reset();
        rt_reset = 1'b1;
        @(posedge rt_clk);
        @(posedge rt_clk);
        @(negedge rt_clk);
        rt_reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag, input bit sel);
        snap(sel);
        check({tag, "_we"}, 32'(s_we), 32'd0);
        check({tag, "_nib"}, 32'(s_nib), 32'd0);
        check({tag, "_done"}, 32'(s_pd), 32'd0);
        check({tag, "_cnt"}, 32'(s_cnt), 32'd0);
        check({tag, "_full"}, 32'(s_full), 32'd0);
        check({tag, "_ovf"}, 32'(s_ovf), 32'd0);
    endtask

    initial begin
        bus_a.write_req = 1'b0; bus_a.spike_packet = '0; bus_a.receive_full = 1'b0;
        bus_b.write_req = 1'b0; bus_b.spike_packet = '0; bus_b.receive_full = 1'b0;
        fill_pkts[0] = 32'hA1B2C3D4;
        fill_pkts[1] = 32'h0F1E2D3C;
        fill_pkts[2] = 32'h55AA33CC;
        fill_pkts[3] = 32'h89ABCDEF;
        fill_pkts[4] = 32'h13579BDF;
        fill_pkts[5] = 32'hFEEDFACE;
        pd_pulses = 0;

        do_reset();
        check_reset_outputs("rst_a", 1'b0);
        check_reset_outputs("rst_b", 1'b1);

        // Single packet: first nibble two cycles after the write strobe.
        cycle(0, 1'b1, 32'h12345678, 1'b0);
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("single_latency_we", 32'(s_we), 32'd0);
        expect_stream("single", 0, 32'h12345678, 1'b1);
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("single_idle_we", 32'(s_we), 32'd0);
        check("single_cnt", 32'(s_cnt), 32'd1);

        // Stall for 3 cycles while nibble 3 is on the bus.
        cycle(0, 1'b1, 32'h12345678, 1'b0);
        cycle(0, 1'b0, 32'h0, 1'b0);
        span = 0;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1'b0, 32'h0, 1'b0);
            span++;
            check("stall_pre_we", 32'(s_we), 32'd1);
            check("stall_pre_nib", 32'(s_nib), 32'(i + 1));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1'b0, 32'h0, 1'b1);
            span++;
            check("stall_hold_we", 32'(s_we), 32'd0);
            check("stall_hold_nib", 32'(s_nib), 32'd3);
            check("stall_hold_done", 32'(s_pd), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1'b0, 32'h0, 1'b0);
            span++;
            check("stall_post_we", 32'(s_we), 32'd1);
            check("stall_post_nib", 32'(s_nib), 32'(i + 3));
            check("stall_post_done", 32'(s_pd), (i == 5) ? 32'd1 : 32'd0);
        end
        check("stall_span", 32'(span), 32'd11);
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("stall_cnt", 32'(s_cnt), 32'd2);

        // Back-to-back packets: 16 contiguous flits.
        cycle(0, 1'b1, 32'hAAAAAAAA, 1'b0);
        cycle(0, 1'b1, 32'h55555555, 1'b0);
        check("b2b_first_we", 32'(s_we), 32'd0);
        expect_stream("b2b_a", 0, 32'hAAAAAAAA, 1'b1);
        expect_stream("b2b_5", 0, 32'h55555555, 1'b1);
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("b2b_idle_we", 32'(s_we), 32'd0);
        check("b2b_cnt", 32'(s_cnt), 32'd4);

        // Reset while nibble 5 of 0xDEADBEEF is on the bus.
        cycle(0, 1'b1, 32'hDEADBEEF, 1'b0);
        cycle(0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1'b0, 32'h0, 1'b0);
            check("midrst_nib", 32'(s_nib), 32'(exp_nib(32'hDEADBEEF, i, 1'b1)));
        end
        @(posedge rt_clk);
        #1;
        snap(0);
        check("midrst_pre_nib", 32'(s_nib), 32'hB);
        rt_reset = 1'b1;
        #1;
        check_reset_outputs("midrst", 1'b0);
        @(negedge rt_clk);
        @(negedge rt_clk);
        rt_reset = 1'b0;
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("midrst_idle_we", 32'(s_we), 32'd0);
        cycle(0, 1'b1, 32'h00000001, 1'b0);
        cycle(0, 1'b0, 32'h0, 1'b0);
        expect_stream("midrst_new", 0, 32'h00000001, 1'b1);
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("midrst_cnt", 32'(s_cnt), 32'd1);

        // Fill under backpressure: A1 shifting, A2..A5 queued, A6 dropped.
        do_reset();
        check_reset_outputs("fill_rst", 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 1'b1, fill_pkts[k], 1'b1);
            check("fill_we", 32'(s_we), 32'd0);
            check("fill_full", 32'(s_full), (k == 5) ? 32'd1 : 32'd0);
        end
        check("fill_head_nib", 32'(s_nib), 32'hA);
        check("fill_ovf_before", 32'(s_ovf), 32'd0);
        cycle(0, 1'b0, 32'h0, 1'b1);
        check("fill_ovf", 32'(s_ovf), 32'd1);
        check("fill_full_held", 32'(s_full), 32'd1);
        pd_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            expect_stream("drain", 0, fill_pkts[k], 1'b1);
        end
        cycle(0, 1'b0, 32'h0, 1'b0);
        check("drain_idle_we", 32'(s_we), 32'd0);
        check("drain_pulses", 32'(pd_pulses), 32'd5);
        check("drain_cnt", 32'(s_cnt), 32'd5);
        check("drain_full", 32'(s_full), 32'd0);
        check("drain_ovf_sticky", 32'(s_ovf), 32'd1);

        // LSB-first instance.
        cycle(1, 1'b1, 32'h12345678, 1'b0);
        cycle(1, 1'b0, 32'h0, 1'b0);
        check("lsb_latency_we", 32'(s_we), 32'd0);
        expect_stream("lsb", 1, 32'h12345678, 1'b0);
        cycle(1, 1'b0, 32'h0, 1'b0);
        check("lsb_idle_we", 32'(s_we), 32'd0);
        check("lsb_cnt", 32'(s_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
